// File: rtl/jtdd2_sub_romfetch.sv
// jtdd2_sub_romfetch
// ROM fetch adapter between the Double Dragon 2 sub CPU ROM bus and an SDRAM
// slot that returns 32-bit words. Byte reads from the CPU are served from a
// one-line, 4-byte cache. A miss issues a single SDRAM word request. Once a
// request has been issued, it always runs to completion.
//
// Parameters
//   AW    SDRAM word-address width (32-bit words)
//   BASE  word offset of the sub ROM inside the SDRAM slot
//
// Ports
//   clk, rst_n  clock (posedge) and asynchronous active-low reset
//   flush       invalidate the cache line; a level also blocks new requests
//   cpu_addr    sub CPU byte address
//   cpu_cs      ROM chip select
//   cpu_data    byte returned to the CPU
//   cpu_ok      cpu_data is valid for the current cpu_addr
//   sdr_addr    SDRAM word address = BASE + cpu_addr[15:2], modulo 2^AW
//   sdr_req     request strobe, held until sdr_ack
//   sdr_ack     SDRAM accepted the request
//   sdr_dok     sdr_data valid (one-cycle pulse)
//   sdr_data    SDRAM word, little endian (byte n at [8n+7:8n])
module jtdd2_sub_romfetch #(
  parameter int          AW   = 14,
  parameter int unsigned BASE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [15:0]   cpu_addr,
  input  logic          cpu_cs,
  output logic [7:0]    cpu_data,
  output logic          cpu_ok,
  output logic [AW-1:0] sdr_addr,
  output logic          sdr_req,
  input  logic          sdr_ack,
  input  logic          sdr_dok,
  input  logic [31:0]   sdr_data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state, next_state;
  logic [31:0]   line;
  logic [13:0]   tag, req_tag;
  logic          valid, kill;
  logic          ok_r;
  logic [15:0]   addr_r;
  logic          hit, issue, fill;
  logic [7:0]    sel_byte;
  logic [AW-1:0] base_w, index_w;

  assign hit     = cpu_cs & valid & (tag == cpu_addr[15:2]);
  assign base_w  = AW'(BASE);
  assign index_w = AW'(cpu_addr[15:2]);

  // cpu_ok is qualified against the live bus. A registered hit therefore
  // cannot leak into a cycle where the address moved or cs dropped.
  assign cpu_ok = ok_r & cpu_cs & (addr_r == cpu_addr);

  always_comb begin
    sel_byte = line[7:0];
    case (cpu_addr[1:0])
      2'd1:    sel_byte = line[15:8];
      2'd2:    sel_byte = line[23:16];
      2'd3:    sel_byte = line[31:24];
      default: sel_byte = line[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // The miss is started only from IDLE. The fill cycle always lands back in
  // IDLE, so at least one idle cycle separates a fill from the next request.
  // When ack and dok arrive together in REQ, the WAIT state is skipped.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    fill       = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_cs && !hit && !flush) begin
          issue      = 1'b1;
          next_state = REQ;
        end
      end
      REQ: begin
        if (sdr_ack) begin
          if (sdr_dok) begin
            fill       = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (sdr_dok) begin
          fill       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // A flush seen while a request is outstanding sets kill. The line is still
  // written when the data arrives, but it is marked invalid. A flush in the
  // fill cycle itself takes priority over the fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line     <= '0;
      tag      <= '0;
      req_tag  <= '0;
      valid    <= 1'b0;
      kill     <= 1'b0;
      sdr_req  <= 1'b0;
      sdr_addr <= '0;
      cpu_data <= '0;
      ok_r     <= 1'b0;
      addr_r   <= '0;
    end else begin
      ok_r     <= hit;
      addr_r   <= cpu_addr;
      cpu_data <= sel_byte;
      if (issue) begin
        req_tag  <= cpu_addr[15:2];
        sdr_addr <= base_w + index_w;
        sdr_req  <= 1'b1;
      end else if (state == REQ && sdr_ack) begin
        sdr_req <= 1'b0;
      end
      if (fill) begin
        line <= sdr_data;
        tag  <= req_tag;
      end
      if (flush)     valid <= 1'b0;
      else if (fill) valid <= !kill;
      if (state == IDLE) kill <= 1'b0;
      else if (flush)    kill <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtdd2_sub_romfetch.sv
// tb_jtdd2_sub_romfetch
// Directed scenarios followed by a randomized run for jtdd2_sub_romfetch.
// The SDRAM contents come from a fixed function of the word address. Any byte
// reported valid must therefore equal that function at the current CPU
// address. A second instance with BASE=0x3FFF shares every input and is used
// to check the address offset and its wrap-around.
module tb_jtdd2_sub_romfetch;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [15:0] cpu_addr;
  logic        cpu_cs;
  logic [7:0]  cpu_data, b_data;
  logic        cpu_ok, b_ok;
  logic [13:0] sdr_addr, b_addr;
  logic        sdr_req, b_req;
  logic        sdr_ack;
  logic        sdr_dok;
  logic [31:0] sdr_data;

  int checks = 0;
  int passed = 0;

  jtdd2_sub_romfetch #(.AW(14), .BASE(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cpu_addr(cpu_addr), .cpu_cs(cpu_cs),
    .cpu_data(cpu_data), .cpu_ok(cpu_ok), .sdr_addr(sdr_addr), .sdr_req(sdr_req),
    .sdr_ack(sdr_ack), .sdr_dok(sdr_dok), .sdr_data(sdr_data)
  );

  jtdd2_sub_romfetch #(.AW(14), .BASE(32'h3FFF)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cpu_addr(cpu_addr), .cpu_cs(cpu_cs),
    .cpu_data(b_data), .cpu_ok(b_ok), .sdr_addr(b_addr), .sdr_req(b_req),
    .sdr_ack(sdr_ack), .sdr_dok(sdr_dok), .sdr_data(sdr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SDRAM contents: a fixed pattern derived from the word address
  function automatic logic [31:0] mem_word(input logic [13:0] w);
    return {2'b01, w, 2'b10, w} ^ 32'hA5C3_1E77;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    logic [31:0] w;
    w = mem_word(a[15:2]);
    return w[8*a[1:0] +: 8];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic cs, input logic fl);
    cpu_addr = a;
    cpu_cs   = cs;
    flush    = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sdram(input logic ack, input logic dok, input logic [31:0] d);
    sdr_ack  = ack;
    sdr_dok  = dok;
    sdr_data = d;
  endtask

  initial begin
    int          stall, max_stall, dly;
    logic        prev_req, prev_ack, waiting;
    logic [13:0] prev_sdr, resp_w;

    rst_n = 1'b1;
    sdram(0, 0, 0);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    checkOutput("reset_req",  sdr_req,  0);
    checkOutput("reset_addr", sdr_addr, 0);
    checkOutput("reset_data", cpu_data, 0);
    checkOutput("reset_ok",   cpu_ok,   0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checkOutput("idle_no_req", sdr_req, 0);

    $display("[TB] miss at 0x1234");
    applyStimulus(16'h1234, 1'b1, 1'b0);
    tick();
    checkOutput("miss_req",    sdr_req, 1);
    checkOutput("miss_addr",   sdr_addr, 14'h048D);
    checkOutput("miss_b_addr", b_addr,   14'h048C);
    tick();
    checkOutput("miss_hold_req",  sdr_req,  1);
    checkOutput("miss_hold_addr", sdr_addr, 14'h048D);
    sdram(1, 0, 0);
    tick();
    sdram(0, 0, 0);
    checkOutput("miss_req_drop", sdr_req, 0);
    tick();
    checkOutput("miss_wait_ok", cpu_ok, 0);
    sdram(0, 1, 32'hDDCC_BBAA);
    tick();
    sdram(0, 0, 0);
    checkOutput("fill_ok_early", cpu_ok, 0);
    tick();
    checkOutput("fill_ok",   cpu_ok,   1);
    checkOutput("fill_data", cpu_data, 8'hAA);

    $display("[TB] hits within the line");
    applyStimulus(16'h1235, 1'b1, 1'b0);
    checkOutput("hit1_ok_drop", cpu_ok, 0);
    tick();
    checkOutput("hit1_ok",   cpu_ok,   1);
    checkOutput("hit1_data", cpu_data, 8'hBB);
    applyStimulus(16'h1237, 1'b1, 1'b0);
    checkOutput("hit3_ok_drop", cpu_ok, 0);
    tick();
    checkOutput("hit3_ok",   cpu_ok,   1);
    checkOutput("hit3_data", cpu_data, 8'hDD);
    checkOutput("hit_no_req", sdr_req, 0);
    applyStimulus(16'h1237, 1'b0, 1'b0);
    checkOutput("cs_drop_ok", cpu_ok, 0);

    $display("[TB] flush during WAIT");
    applyStimulus(16'h1240, 1'b1, 1'b0);
    tick();
    checkOutput("fl_req_addr", sdr_addr, 14'h0490);
    sdram(1, 0, 0);
    tick();
    sdram(0, 0, 0);
    applyStimulus(16'h1240, 1'b1, 1'b1);
    tick();
    applyStimulus(16'h1240, 1'b1, 1'b0);
    sdram(0, 1, 32'h1122_3344);
    tick();
    sdram(0, 0, 0);
    checkOutput("fl_ok_after_fill", cpu_ok, 0);
    checkOutput("fl_gap_no_req",    sdr_req, 0);
    tick();
    checkOutput("fl_ok_stays_0", cpu_ok,  0);
    checkOutput("fl_reissue",    sdr_req, 1);
    checkOutput("fl_reissue_addr", sdr_addr, 14'h0490);
    sdram(1, 1, 32'h1122_3344);
    tick();
    sdram(0, 0, 0);
    tick();
    checkOutput("fl_refill_ok",   cpu_ok,   1);
    checkOutput("fl_refill_data", cpu_data, 8'h44);

    $display("[TB] flush held in IDLE blocks requests");
    applyStimulus(16'h5000, 1'b1, 1'b1);
    tick(); tick(); tick();
    checkOutput("flush_blocks", sdr_req, 0);
    applyStimulus(16'h5000, 1'b1, 1'b0);
    tick();
    checkOutput("flush_release_req", sdr_req, 1);
    sdram(1, 1, mem_word(14'h1400));
    tick();
    sdram(0, 0, 0);

    $display("[TB] address change mid-miss");
    applyStimulus(16'h2000, 1'b1, 1'b0);
    tick(); tick();
    checkOutput("mm_first_addr", sdr_addr, 14'h0800);
    sdram(1, 0, 0);
    tick();
    sdram(0, 0, 0);
    applyStimulus(16'h3000, 1'b1, 1'b0);
    tick();
    sdram(0, 1, 32'hA0A1_A2A3);
    tick();
    sdram(0, 0, 0);
    checkOutput("mm_stale_ok", cpu_ok, 0);
    tick();
    checkOutput("mm_second_req",  sdr_req,  1);
    checkOutput("mm_second_addr", sdr_addr, 14'h0C00);
    sdram(1, 1, 32'hB0B1_B2B3);
    tick();
    sdram(0, 0, 0);
    tick();
    checkOutput("mm_ok",   cpu_ok,   1);
    checkOutput("mm_data", cpu_data, 8'hB3);

    $display("[TB] ack+dok together, BASE wrap");
    applyStimulus(16'h0004, 1'b1, 1'b0);
    tick();
    checkOutput("wrap_addr",   sdr_addr, 14'h0001);
    checkOutput("wrap_b_addr", b_addr,   14'h0000);
    checkOutput("wrap_b_req",  b_req,    1);
    sdram(1, 1, 32'h5566_7788);
    tick();
    sdram(0, 0, 0);
    checkOutput("ackdok_req_drop", sdr_req, 0);
    tick();
    checkOutput("ackdok_ok",     cpu_ok, 1);
    checkOutput("ackdok_data",   cpu_data, 8'h88);
    checkOutput("ackdok_b_ok",   b_ok, 1);
    checkOutput("ackdok_b_data", b_data, 8'h88);

    $display("[TB] async reset mid-WAIT");
    applyStimulus(16'h0100, 1'b1, 1'b0);
    tick();
    sdram(1, 0, 0);
    tick();
    sdram(0, 0, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_req",  sdr_req,  0);
    checkOutput("rst_addr", sdr_addr, 0);
    checkOutput("rst_data", cpu_data, 0);
    checkOutput("rst_ok",   cpu_ok,   0);
    tick();
    rst_n = 1'b1;
    applyStimulus(16'h0000, 1'b1, 1'b0);
    tick();
    checkOutput("rst_fresh_req",  sdr_req,  1);
    checkOutput("rst_fresh_addr", sdr_addr, 14'h0000);
    sdram(1, 1, mem_word(14'h0000));
    tick();
    sdram(0, 0, 0);

    $display("[TB] randomized run");
    stall = 0; max_stall = 0; dly = 0;
    prev_req = 1'b0; prev_ack = 1'b0; waiting = 1'b0;
    prev_sdr = '0; resp_w = '0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (cpu_ok) checkOutput("rnd_data", cpu_data, mem_byte(cpu_addr));
      if (b_ok)   checkOutput("rnd_b_data", b_data, mem_byte(cpu_addr));
      if (prev_req && !prev_ack)
        checkOutput("rnd_hold", {sdr_req, sdr_addr}, {1'b1, prev_sdr});
      else if (prev_req && prev_ack)
        checkOutput("rnd_drop", sdr_req, 0);
      else if (sdr_req)
        checkOutput("rnd_issue_addr", sdr_addr, cpu_addr[15:2]);
      if (sdr_req)
        checkOutput("rnd_b_addr", b_addr, 14'(sdr_addr + 14'h3FFF));
      if (cpu_ok || !cpu_cs) stall = 0;
      else stall++;
      if (stall > max_stall) max_stall = stall;
      prev_req = sdr_req;
      prev_sdr = sdr_addr;

      sdram(0, 0, 0);
      if (waiting) begin
        if (dly == 0) begin
          sdram(0, 1, mem_word(resp_w));
          waiting = 1'b0;
        end else begin
          dly--;
        end
      end else if (sdr_req && ($urandom % 2 == 0)) begin
        resp_w = sdr_addr;
        if ($urandom % 4 == 0) begin
          sdram(1, 1, mem_word(sdr_addr));
        end else begin
          sdram(1, 0, 0);
          waiting = 1'b1;
          dly = $urandom_range(0, 3);
        end
      end
      prev_ack = sdr_ack;

      if ($urandom % 8 == 0) begin
        applyStimulus(16'h4000 + 16'($urandom_range(0, 31)), ($urandom % 10) != 0,
                      ($urandom % 32) == 0);
        stall = 0;
      end else begin
        applyStimulus(cpu_addr, cpu_cs, 1'b0);
      end
    end
    checkOutput("rnd_max_stall_ok", max_stall < 60, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
